// File: rtl/dt_engine_param.sv
// Two-pass distance-transform engine: a raster forward pass and a reverse-raster
// backward pass over a packed binary image, with a 4/8-neighbour metric and saturating distances.
module dt_engine_param #(
  parameter int unsigned IMG_W  = 128,
  parameter int unsigned IMG_H  = 128,
  parameter int unsigned STI_W  = 16,
  parameter int unsigned DIST_W = 8,
  parameter int unsigned SA_W   = $clog2(IMG_W*IMG_H/STI_W),
  parameter int unsigned RA_W   = $clog2(IMG_W*IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_8n,
  output logic              busy,
  output logic              forward_complete,
  output logic              done,
  output logic              sti_rd,
  output logic [SA_W-1:0]   sti_addr,
  input  logic [STI_W-1:0]  sti_di,
  output logic              res_rd,
  output logic              res_wr,
  output logic [RA_W-1:0]   res_addr,
  output logic [DIST_W-1:0] res_do,
  input  logic [DIST_W-1:0] res_di
);

  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned BW = (STI_W > 1) ? $clog2(STI_W) : 1;
  localparam logic [XW-1:0]     X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(IMG_H - 1);
  localparam logic [BW-1:0]     B_LAST = BW'(STI_W - 1);
  localparam logic [RA_W-1:0]   ROW    = RA_W'(IMG_W);
  localparam logic [DIST_W-1:0] D_MAX  = '1;

  typedef enum logic [3:0] {
    IDLE, FW_FETCH, FW_NRD, FW_WR, FW_END, BW_SELF, BW_NRD, BW_WR, FIN
  } state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [RA_W-1:0]   p_q, p_d;
  logic [BW-1:0]     b_q, b_d;
  logic [STI_W-1:0]  word_q, word_d;
  logic [2:0]        n_q, n_d;
  logic              pend_q, pend_d;
  logic [DIST_W-1:0] min_q, min_d;
  logic [DIST_W-1:0] f_q, f_d;
  logic              mode_q, mode_d;
  logic              arm_q, arm_d;
  logic              sti_rd_q, sti_rd_d;
  logic [SA_W-1:0]   sti_addr_q, sti_addr_d;
  logic              res_rd_q, res_rd_d;
  logic              res_wr_q, res_wr_d;
  logic [RA_W-1:0]   res_addr_q, res_addr_d;
  logic [DIST_W-1:0] res_do_q, res_do_d;
  logic              busy_q, busy_d;
  logic              fc_q, fc_d;
  logic              done_q, done_d;

  function automatic logic [DIST_W-1:0] inc_sat(input logic [DIST_W-1:0] v);
    return (v == D_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [DIST_W-1:0] umin(input logic [DIST_W-1:0] a,
                                             input logic [DIST_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Neighbour candidates; bit order fw: NW,N,NE,W  bw: E,SW,S,SE
  logic              fw;
  logic              x_lo, x_hi, y_lo, y_hi;
  logic [3:0]        in_set, in_img, nbr_ok;
  logic [RA_W-1:0]   na [4];
  logic              found, edge_zero;
  logic [1:0]        sel;
  logic [DIST_W-1:0] base, acc;

  always_comb begin
    fw   = (state_q == FW_NRD);
    x_lo = (x_q == '0);
    x_hi = (x_q == X_LAST);
    y_lo = (y_q == '0);
    y_hi = (y_q == Y_LAST);
    if (fw) begin
      in_set = {1'b1, mode_q, 1'b1, mode_q};
      in_img = {!x_lo, !y_lo && !x_hi, !y_lo, !y_lo && !x_lo};
      na[0]  = p_q - ROW - 1'b1;
      na[1]  = p_q - ROW;
      na[2]  = p_q - ROW + 1'b1;
      na[3]  = p_q - 1'b1;
    end else begin
      in_set = {mode_q, 1'b1, mode_q, 1'b1};
      in_img = {!y_hi && !x_hi, !y_hi, !y_hi && !x_lo, !x_hi};
      na[0]  = p_q + 1'b1;
      na[1]  = p_q + ROW - 1'b1;
      na[2]  = p_q + ROW;
      na[3]  = p_q + ROW + 1'b1;
    end
    nbr_ok    = in_set & in_img;
    edge_zero = |(in_set & ~in_img);
    found     = 1'b0;
    sel       = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!found && (i >= 32'(n_q)) && nbr_ok[i]) begin
        found = 1'b1;
        sel   = 2'(i);
      end
    end
    // First NRD cycle seeds the running minimum; an out-of-image neighbour pins it to 0.
    base = (n_q == '0) ? (edge_zero ? '0 : D_MAX) : min_q;
    acc  = pend_q ? umin(base, res_di) : base;
  end

  always_comb begin
    logic step_back;
    step_back  = 1'b0;
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    p_d        = p_q;
    b_d        = b_q;
    word_d     = word_q;
    n_d        = n_q;
    pend_d     = pend_q;
    min_d      = min_q;
    f_d        = f_q;
    mode_d     = mode_q;
    arm_d      = 1'b1;
    sti_rd_d   = 1'b0;
    sti_addr_d = sti_addr_q;
    res_rd_d   = 1'b0;
    res_wr_d   = 1'b0;
    res_addr_d = res_addr_q;
    res_do_d   = res_do_q;
    busy_d     = busy_q;
    fc_d       = fc_q;
    done_d     = done_q;

    case (state_q)
      IDLE: begin
        if (start && arm_q) begin
          state_d    = FW_FETCH;
          x_d        = '0;
          y_d        = '0;
          p_d        = '0;
          b_d        = '0;
          mode_d     = mode_8n;
          busy_d     = 1'b1;
          fc_d       = 1'b0;
          done_d     = 1'b0;
          sti_rd_d   = 1'b1;
          sti_addr_d = '0;
        end
      end
      FW_FETCH: begin
        word_d  = sti_di;
        n_d     = '0;
        pend_d  = 1'b0;
        state_d = FW_NRD;
      end
      FW_NRD: begin
        if (word_q[STI_W-1] && found) begin
          res_rd_d   = 1'b1;
          res_addr_d = na[sel];
          n_d        = {1'b0, sel} + 3'd1;
          pend_d     = 1'b1;
          min_d      = acc;
        end else begin
          state_d    = FW_WR;
          res_wr_d   = 1'b1;
          res_addr_d = p_q;
          res_do_d   = word_q[STI_W-1] ? inc_sat(acc) : '0;
        end
      end
      FW_WR: begin
        n_d    = '0;
        pend_d = 1'b0;
        if (x_hi && y_hi) begin
          state_d = FW_END;
          fc_d    = 1'b1;
        end else begin
          p_d = p_q + 1'b1;
          if (x_hi) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          if (b_q == B_LAST) begin
            b_d        = '0;
            state_d    = FW_FETCH;
            sti_rd_d   = 1'b1;
            sti_addr_d = sti_addr_q + 1'b1;
          end else begin
            b_d     = b_q + 1'b1;
            word_d  = word_q << 1;
            state_d = FW_NRD;
          end
        end
      end
      FW_END: begin
        state_d    = BW_SELF;
        res_rd_d   = 1'b1;
        res_addr_d = p_q;
      end
      BW_SELF: begin
        n_d    = '0;
        pend_d = 1'b0;
        if (res_di != '0) begin
          f_d     = res_di;
          state_d = BW_NRD;
        end else begin
          step_back = 1'b1;
        end
      end
      BW_NRD: begin
        if (found) begin
          res_rd_d   = 1'b1;
          res_addr_d = na[sel];
          n_d        = {1'b0, sel} + 3'd1;
          pend_d     = 1'b1;
          min_d      = acc;
        end else begin
          state_d    = BW_WR;
          res_wr_d   = 1'b1;
          res_addr_d = p_q;
          res_do_d   = umin(f_q, inc_sat(acc));
        end
      end
      BW_WR:   step_back = 1'b1;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (step_back) begin
      if (p_q == '0) begin
        state_d = FIN;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end else begin
        p_d = p_q - 1'b1;
        if (x_lo) begin
          x_d = X_LAST;
          y_d = y_q - 1'b1;
        end else begin
          x_d = x_q - 1'b1;
        end
        state_d    = BW_SELF;
        res_rd_d   = 1'b1;
        res_addr_d = p_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      p_q        <= '0;
      b_q        <= '0;
      word_q     <= '0;
      n_q        <= '0;
      pend_q     <= 1'b0;
      min_q      <= '0;
      f_q        <= '0;
      mode_q     <= 1'b0;
      arm_q      <= 1'b0;
      sti_rd_q   <= 1'b0;
      sti_addr_q <= '0;
      res_rd_q   <= 1'b0;
      res_wr_q   <= 1'b0;
      res_addr_q <= '0;
      res_do_q   <= '0;
      busy_q     <= 1'b0;
      fc_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      p_q        <= p_d;
      b_q        <= b_d;
      word_q     <= word_d;
      n_q        <= n_d;
      pend_q     <= pend_d;
      min_q      <= min_d;
      f_q        <= f_d;
      mode_q     <= mode_d;
      arm_q      <= arm_d;
      sti_rd_q   <= sti_rd_d;
      sti_addr_q <= sti_addr_d;
      res_rd_q   <= res_rd_d;
      res_wr_q   <= res_wr_d;
      res_addr_q <= res_addr_d;
      res_do_q   <= res_do_d;
      busy_q     <= busy_d;
      fc_q       <= fc_d;
      done_q     <= done_d;
    end
  end

  assign busy             = busy_q;
  assign forward_complete = fc_q;
  assign done             = done_q;
  assign sti_rd           = sti_rd_q;
  assign sti_addr         = sti_addr_q;
  assign res_rd           = res_rd_q;
  assign res_wr           = res_wr_q;
  assign res_addr         = res_addr_q;
  assign res_do           = res_do_q;

endmodule

// File: tb/tb_dt_engine_param.sv
// Bench for dt_engine_param: two 16x16 instances (8-bit and 2-bit distances) with
// behavioural ROM/RAM, directed images, hand-computed pixels and a software reference.
module tb_dt_engine_param;
  localparam int W = 16;
  localparam int H = 16;
  localparam int N = W * H;
  localparam int LIMIT = 5000;
  localparam int FDY [4] = '{-1, -1, -1, 0};
  localparam int FDX [4] = '{-1, 0, 1, -1};
  localparam int BDY [4] = '{0, 1, 1, 1};
  localparam int BDX [4] = '{1, -1, 0, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, fill;
  logic start_a, mode_a, start_b, mode_b;
  logic busy_a, fc_a, done_a, sti_rd_a, res_rd_a, res_wr_a;
  logic busy_b, fc_b, done_b, sti_rd_b, res_rd_b, res_wr_b;
  logic [3:0]  sti_addr_a, sti_addr_b;
  logic [15:0] sti_di_a, sti_di_b;
  logic [7:0]  res_addr_a, res_addr_b;
  logic [7:0]  res_do_a, res_di_a;
  logic [1:0]  res_do_b, res_di_b;

  logic [15:0] rom [H];
  logic [7:0]  ram_a [N];
  logic [1:0]  ram_b [N];
  logic        img [H][W];
  int          fwm [H][W];
  int          exm [H][W];
  int          n_chk = 0;
  int          n_err = 0;

  dt_engine_param #(.IMG_W(W), .IMG_H(H), .STI_W(16), .DIST_W(8)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .mode_8n(mode_a),
    .busy(busy_a), .forward_complete(fc_a), .done(done_a),
    .sti_rd(sti_rd_a), .sti_addr(sti_addr_a), .sti_di(sti_di_a),
    .res_rd(res_rd_a), .res_wr(res_wr_a), .res_addr(res_addr_a),
    .res_do(res_do_a), .res_di(res_di_a)
  );

  dt_engine_param #(.IMG_W(W), .IMG_H(H), .STI_W(16), .DIST_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mode_8n(mode_b),
    .busy(busy_b), .forward_complete(fc_b), .done(done_b),
    .sti_rd(sti_rd_b), .sti_addr(sti_addr_b), .sti_di(sti_di_b),
    .res_rd(res_rd_b), .res_wr(res_wr_b), .res_addr(res_addr_b),
    .res_do(res_do_b), .res_di(res_di_b)
  );

  always @(negedge clk) begin
    if (sti_rd_a) sti_di_a <= rom[sti_addr_a];
    if (res_rd_a) res_di_a <= ram_a[res_addr_a];
    if (sti_rd_b) sti_di_b <= rom[sti_addr_b];
    if (res_rd_b) res_di_b <= ram_b[res_addr_b];
  end

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < N; i++) begin
        ram_a[i] <= 8'hAA;
        ram_b[i] <= 2'b10;
      end
    end else begin
      if (res_wr_a) ram_a[res_addr_a] <= res_do_a;
      if (res_wr_b) ram_b[res_addr_b] <= res_do_b;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_img();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = 1'b0;
  endtask

  task automatic set_block(input int lo, input int hi);
    for (int y = lo; y <= hi; y++)
      for (int x = lo; x <= hi; x++) img[y][x] = 1'b1;
  endtask

  task automatic build_rom();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) rom[y][W-1-x] = img[y][x];
  endtask

  // Reference two-pass transform over the bench image.
  task automatic model(input logic m8, input int maxv);
    int m, ny, nx, v;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (!img[y][x]) begin
          fwm[y][x] = 0;
        end else begin
          m = 1 << 20;
          for (int k = 0; k < 4; k++) begin
            if (!m8 && (k == 0 || k == 2)) continue;
            ny = y + FDY[k];
            nx = x + FDX[k];
            if (ny < 0 || nx < 0 || nx >= W) m = 0;
            else if (fwm[ny][nx] < m) m = fwm[ny][nx];
          end
          fwm[y][x] = (m + 1 > maxv) ? maxv : m + 1;
        end
        exm[y][x] = fwm[y][x];
      end
    end
    for (int y = H - 1; y >= 0; y--) begin
      for (int x = W - 1; x >= 0; x--) begin
        if (exm[y][x] != 0) begin
          m = 1 << 20;
          for (int k = 0; k < 4; k++) begin
            if (!m8 && (k == 1 || k == 3)) continue;
            ny = y + BDY[k];
            nx = x + BDX[k];
            if (ny >= H || nx < 0 || nx >= W) m = 0;
            else if (exm[ny][nx] < m) m = exm[ny][nx];
          end
          v = (m + 1 > maxv) ? maxv : m + 1;
          if (v < exm[y][x]) exm[y][x] = v;
        end
      end
    end
  endtask

  function automatic int cmp_a(input bit fwd);
    int e = 0;
    for (int i = 0; i < N; i++)
      if (int'(ram_a[i]) != (fwd ? fwm[i/W][i%W] : exm[i/W][i%W])) e++;
    return e;
  endfunction

  function automatic int cmp_b();
    int e = 0;
    for (int i = 0; i < N; i++)
      if (int'(ram_b[i]) != exm[i/W][i%W]) e++;
    return e;
  endfunction

  task automatic run_a(input logic m8, input bit poke);
    int cyc, fcc;
    bit fcs;
    cyc = 0;
    fcc = 0;
    fcs = 1'b0;
    fill = 1'b1;
    @(posedge clk); #1 fill = 1'b0;
    mode_a = m8;
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    while (!done_a && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (fc_a && !fcs) begin
        fcs = 1'b1;
        fcc = cyc;
        chk("fw_snapshot", cmp_a(1'b1), 0);
      end
      if (poke && fcs && cyc == fcc + 20) begin
        start_a = 1'b1;
        mode_a = ~m8;
      end
      if (poke && fcs && cyc == fcc + 21) begin
        start_a = 1'b0;
        chk("busy_held", busy_a, 1);
      end
      if (poke && fcs && cyc == fcc + 22) chk("start_ignored_fc", fc_a, 1);
    end
    chk("done_timeout", done_a, 1);
    chk("fc_before_done", int'(fcs && fcc < cyc), 1);
    chk("busy_at_done", busy_a, 0);
    chk("pixel_budget", int'(cyc <= 14 * N + 8), 1);
    chk("final_image", cmp_a(1'b0), 0);
  endtask

  task automatic run_b();
    int cyc;
    cyc = 0;
    fill = 1'b1;
    @(posedge clk); #1 fill = 1'b0;
    mode_b = 1'b1;
    start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    while (!done_b && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    chk("b_done_timeout", done_b, 1);
    chk("b_final_image", cmp_b(), 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    fill = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    mode_a = 1'b1;
    mode_b = 1'b1;
    clear_img();
    build_rom();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", int'(|{busy_a, fc_a, done_a, sti_rd_a, sti_addr_a, res_rd_a,
                             res_wr_a, res_addr_a, res_do_a}), 0);
    // start coincident with reset release must be dropped
    start_a = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    @(negedge clk);
    chk("start_at_reset_release", int'(busy_a | sti_rd_a), 0);

    clear_img();
    img[5][5] = 1'b1;
    build_rom();
    model(1'b1, 255);
    run_a(1'b1, 1'b0);
    chk("single_85", ram_a[85], 1);

    clear_img();
    set_block(2, 6);
    build_rom();
    model(1'b1, 255);
    run_a(1'b1, 1'b1);
    chk("blk_4_4", ram_a[4*W+4], 3);
    chk("blk_3_3", ram_a[3*W+3], 2);
    chk("blk_2_2", ram_a[2*W+2], 1);
    chk("blk_6_4", ram_a[4*W+6], 1);
    chk("blk_bg_0_0", ram_a[0], 0);

    img[4][4] = 1'b0;
    build_rom();
    model(1'b1, 255);
    run_a(1'b1, 1'b0);
    chk("hole8_3_3", ram_a[3*W+3], 1);
    chk("hole8_4_3", ram_a[3*W+4], 1);
    chk("hole8_4_4", ram_a[4*W+4], 0);
    model(1'b0, 255);
    run_a(1'b0, 1'b0);
    chk("hole4_3_3", ram_a[3*W+3], 2);
    chk("hole4_4_3", ram_a[3*W+4], 1);
    chk("hole4_4_4", ram_a[4*W+4], 0);

    // abort mid forward pass, then a clean rerun
    fill = 1'b1;
    @(posedge clk); #1 fill = 1'b0;
    mode_a = 1'b0;
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (300) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("abort_outs", int'(|{busy_a, fc_a, done_a, sti_rd_a, sti_addr_a, res_rd_a,
                                res_wr_a, res_addr_a, res_do_a}), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_a(1'b0, 1'b0);
    chk("rerun_3_3", ram_a[3*W+3], 2);

    clear_img();
    set_block(2, 10);
    build_rom();
    model(1'b1, 3);
    run_b();
    chk("sat_6_6", ram_b[6*W+6], 3);
    chk("sat_2_6", ram_b[6*W+2], 1);
    chk("sat_3_6", ram_b[6*W+3], 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
